// File: rtl/decoder_out_encoder_if.sv
// Handshake bundle for decoder_out_encoder: one-hot word in, encoded index and status flags out.
// The slave modport is the encoder's view of the bundle; the master modport is the driving side.
interface decoder_out_encoder_if #(
    parameter int decoder_in_WIDTH = 8
);
    localparam int IDX_WIDTH = $clog2(decoder_in_WIDTH);

    logic [decoder_in_WIDTH-1:0] in;
    logic                        in_valid;
    logic                        in_ready;
    logic [IDX_WIDTH-1:0]        idx;
    logic                        zero_hot;
    logic                        multi_hot;
    logic                        out_valid;
    logic                        out_ready;

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, idx, zero_hot, multi_hot, out_valid
    );

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, idx, zero_hot, multi_hot, out_valid
    );
endinterface

// File: rtl/decoder_out_encoder.sv
// Sequential priority encoder with a 2-entry output buffer (EMPTY/ONE/TWO).
// Optional saturating error counter is enabled by defining DECODER_OUT_ERR_CNT_EN.
module decoder_out_encoder #(
    parameter int decoder_in_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef DECODER_OUT_ERR_CNT_EN
    input  logic                        err_clr,
    output logic [7:0]                  err_cnt,
`endif
    decoder_out_encoder_if.slave        bus
);
    localparam int IDX_WIDTH = $clog2(decoder_in_WIDTH);
    localparam logic [decoder_in_WIDTH-1:0] ONE_W = {{(decoder_in_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] idx;
        logic                 zero_hot;
        logic                 multi_hot;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d, skid_q, skid_d, enc_s;
    logic   in_ready_q, out_valid_q;
    logic   accept_s, pop_s;

    assign accept_s = bus.in_valid && in_ready_q;
    assign pop_s    = out_valid_q && bus.out_ready;

    // Lowest-set-bit encode; scanning downward lets the lowest bit win.
    always_comb begin
        enc_s.idx = {IDX_WIDTH{1'b0}};
        for (int i = decoder_in_WIDTH - 1; i >= 0; i--) begin
            enc_s.idx = bus.in[i] ? IDX_WIDTH'(i) : enc_s.idx;
        end
        enc_s.zero_hot  = (bus.in == {decoder_in_WIDTH{1'b0}});
        enc_s.multi_hot = ((bus.in & (bus.in - ONE_W)) != {decoder_in_WIDTH{1'b0}});
    end

    // Buffer next-state: head always presents the oldest entry.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept_s) begin
                    state_d = ONE;
                    head_d  = enc_s;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && !pop_s) begin
                    state_d = TWO;
                    skid_d  = enc_s;
                end else if (!accept_s && pop_s) begin
                    state_d = EMPTY;
                end else if (accept_s && pop_s) begin
                    head_d  = enc_s;
                end else begin
                    state_d = ONE;
                end
            end
            TWO: begin
                if (pop_s) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end else begin
                    state_d = TWO;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State, entries and handshake flags; flags are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.idx       = head_q.idx;
    assign bus.zero_hot  = head_q.zero_hot;
    assign bus.multi_hot = head_q.multi_hot;

`ifdef DECODER_OUT_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating count of erroneous accepted words; clear wins over increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = 8'd0;
        end else if (accept_s && (enc_s.zero_hot || enc_s.multi_hot) && (err_cnt_q != 8'd255)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_decoder_out_encoder.sv
// Directed bench for decoder_out_encoder: encode, back-pressure, ordering, reset and optional error counter.
module tb_decoder_out_encoder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;
`ifdef DECODER_OUT_ERR_CNT_EN
    logic       err_clr;
    logic [7:0] err_cnt;
`endif

    decoder_out_encoder_if #(.decoder_in_WIDTH(W)) bus ();

    decoder_out_encoder #(.decoder_in_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst_n),
`ifdef DECODER_OUT_ERR_CNT_EN
        .err_clr (err_clr),
        .err_cnt (err_cnt),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] word, input logic vld, input logic rdy);
        bus.in        = word;
        bus.in_valid  = vld;
        bus.out_ready = rdy;
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst_n    = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
`ifdef DECODER_OUT_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        #12;
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_eq("rst_idx",       32'(bus.idx),       32'd0);
        check_eq("rst_zero",      32'(bus.zero_hot),  32'd0);
        check_eq("rst_multi",     32'(bus.multi_hot), 32'd0);
        rst_n = 1'b1;
        step();

        // Single word, latency one cycle.
        drive(8'b0000_0100, 1'b1, 1'b1);
        step();
        check_eq("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check_eq("t1_idx",       32'(bus.idx),       32'd2);
        check_eq("t1_zero",      32'(bus.zero_hot),  32'd0);
        check_eq("t1_multi",     32'(bus.multi_hot), 32'd0);

        // Back-to-back one-hot sweep.
        for (int k = 0; k < W; k++) begin
            drive(8'h01 << k, 1'b1, 1'b1);
            step();
            check_eq("sweep_idx",      32'(bus.idx),       32'(k));
            check_eq("sweep_in_ready", 32'(bus.in_ready),  32'd1);
            check_eq("sweep_valid",    32'(bus.out_valid), 32'd1);
        end
        drive(8'h00, 1'b0, 1'b1);
        step();
        check_eq("sweep_drain", 32'(bus.out_valid), 32'd0);

        // Back-pressure: fill both entries, then drain in order.
        drive(8'h01, 1'b1, 1'b0);
        step();
        check_eq("bp_ready1", 32'(bus.in_ready), 32'd1);
        drive(8'h80, 1'b1, 1'b0);
        step();
        check_eq("bp_ready2", 32'(bus.in_ready), 32'd0);
        drive(8'h02, 1'b1, 1'b0);
        step();
        check_eq("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        check_eq("bp_hold_idx",   32'(bus.idx),      32'd0);
        drive(8'h02, 1'b1, 1'b1);
        step();
        check_eq("bp_pop1_idx",   32'(bus.idx),      32'd7);
        check_eq("bp_pop1_ready", 32'(bus.in_ready), 32'd1);
        step();
        check_eq("bp_pop2_idx",   32'(bus.idx),       32'd1);
        check_eq("bp_pop2_valid", 32'(bus.out_valid), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        step();
        check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

        // Zero-hot and multi-hot words.
        drive(8'h00, 1'b1, 1'b1);
        step();
        check_eq("zh_zero",  32'(bus.zero_hot),  32'd1);
        check_eq("zh_idx",   32'(bus.idx),       32'd0);
        check_eq("zh_multi", 32'(bus.multi_hot), 32'd0);
        drive(8'h28, 1'b1, 1'b1);
        step();
        check_eq("mh_multi", 32'(bus.multi_hot), 32'd1);
        check_eq("mh_idx",   32'(bus.idx),       32'd3);
        check_eq("mh_zero",  32'(bus.zero_hot),  32'd0);
        drive(8'hC0, 1'b1, 1'b1);
        step();
        check_eq("mh2_multi", 32'(bus.multi_hot), 32'd1);
        check_eq("mh2_idx",   32'(bus.idx),       32'd6);
        drive(8'h00, 1'b0, 1'b1);
        step();
`ifdef DECODER_OUT_ERR_CNT_EN
        check_eq("err_cnt_3", 32'(err_cnt), 32'd3);
`endif

        // Reset while full.
        drive(8'h01, 1'b1, 1'b0);
        step();
        drive(8'h02, 1'b1, 1'b0);
        step();
        check_eq("full_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.in_ready),  32'd1);
`ifdef DECODER_OUT_ERR_CNT_EN
        check_eq("mid_rst_err", 32'(err_cnt), 32'd0);
`endif
        drive(8'h00, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        drive(8'h10, 1'b1, 1'b1);
        step();
        check_eq("post_rst_idx",   32'(bus.idx),       32'd4);
        check_eq("post_rst_valid", 32'(bus.out_valid), 32'd1);
        drive(8'h00, 1'b0, 1'b1);
        step();
        check_eq("post_rst_empty", 32'(bus.out_valid), 32'd0);

`ifdef DECODER_OUT_ERR_CNT_EN
        // Saturation and clear priority.
        drive(8'h00, 1'b1, 1'b1);
        for (int n = 0; n < 300; n++) begin
            step();
        end
        check_eq("err_sat", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("err_clr", 32'(err_cnt), 32'd0);
        drive(8'h00, 1'b0, 1'b1);
        step();
        check_eq("err_after_clr", 32'(err_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/decoder_out_encoder.md
Name: decoder_out_encoder

Overview:
- Sequential priority encoder: the inverse of the one-hot decoder.
- Accepts a WIDTH-bit one-hot word over a valid/ready handshake and returns its binary index plus zero-hot and multi-hot status flags.
- Contains a 2-entry output buffer, so upstream can stream one word per cycle under output back-pressure.
- Used as the checking end for decoder output buses and as a standalone encoder in the component library.

Parameters:
- decoder_in_WIDTH, 8, width of the one-hot input word; legal range 2..256.
- IDX_WIDTH: localparam, not overridable; equals $clog2(decoder_in_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- in  input  decoder_in_WIDTH  one-hot word to encode.
- in_valid  input  1  in holds a word.
- in_ready  output  1  block can accept a word this cycle.
- idx  output  IDX_WIDTH  encoded index of the head entry.
- zero_hot  output  1  head entry came from an all-zero word.
- multi_hot  output  1  head entry had more than one bit set.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.

Behaviour:
- Reset (rst low, asynchronous): state EMPTY; idx=0, zero_hot=0, multi_hot=0, out_valid=0, in_ready=1. Both buffer entries cleared.
- Accept condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- Encoding (combinational, before the buffer):
  - idx = position of the lowest set bit in in.
  - zero_hot = (in == 0); idx = 0 in that case.
  - multi_hot = more than one bit set; idx still reports the lowest set bit.
- Buffer FSM, states EMPTY / ONE / TWO; head entry drives the outputs:
  - EMPTY: accept -> ONE; the head loads the encoded word.
  - ONE: accept without pop -> TWO, word loads the skid entry. Pop without accept -> EMPTY. Accept with pop -> stays ONE, head reloads with the new word.
  - TWO: in_ready=0, no accept possible. Pop -> ONE, skid entry moves to head.
- Registered outputs: in_ready = (state != TWO); out_valid = (state != EMPTY).
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 word/cycle while out_ready stays high.
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- Head stability: while out_valid=1 and out_ready=0, idx, zero_hot and multi_hot hold stable.
- in_valid high with in_ready low: word is ignored; upstream must hold it.
- Reset asserted mid-transfer: all entries discarded at once; first accept after release sees EMPTY.
- Input values with X/Z bits are outside the defined behaviour.

Optional Feature:
- Macro: DECODER_OUT_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0]: saturating count of accepted words with zero_hot or multi_hot set.
  - Counter increments on the accept cycle; saturates at 255.
  - Adds input err_clr [1]: synchronous clear, takes priority over an increment in the same cycle.
  - err_cnt resets to 0 on rst.
- When undefined: neither port exists and no counter logic is synthesised.
- Default: undefined.

Test Plan:
- Reset, then in=8'b0000_0100 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, idx=2, zero_hot=0, multi_hot=0.
- Sweep in=1<<k for k=0..7 back-to-back with out_ready=1 -> idx=0..7 in order, one per cycle; in_ready stays 1.
- out_ready=0, push 8'h01, 8'h80, then 8'h02 -> in_ready drops after the second accept. Raise out_ready -> idx sequence 0, 7, 1; no loss.
- in=8'h00 -> zero_hot=1, idx=0. in=8'h28 -> multi_hot=1, idx=3. With DECODER_OUT_ERR_CNT_EN defined, err_cnt=2 afterwards.
- Fill to TWO, then assert rst low mid-cycle -> out_valid=0 and in_ready=1 immediately. After release, push 8'h10 -> idx=4 only.
- With DECODER_OUT_ERR_CNT_EN: 300 accepted zero words -> err_cnt=255. err_clr pulsed together with an erroneous accept -> err_cnt=0.
